// File: rtl/fft_spectrum_buf_if.sv
// rtl/fft_spectrum_buf_if.sv - bin input stream and renderer read handshake for the spectrum buffer
interface fft_spectrum_buf_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_W    = 16
);
    logic                     fft_valid;
    logic                     fft_last;
    logic signed [DATA_W-1:0] fft_re;
    logic signed [DATA_W-1:0] fft_im;
    logic                     fft_ready;
    logic                     vs_in;
    logic                     data_req;
    logic                     fft_point_done;
    logic [ADDR_BITS-1:0]     fft_point_cnt;
    logic [31:0]              fft_data;
    logic                     frame_swapped;
    logic                     frame_err;

    modport master (
        output fft_valid, fft_last, fft_re, fft_im, vs_in, data_req, fft_point_done,
        input  fft_ready, fft_point_cnt, fft_data, frame_swapped, frame_err
    );

    modport slave (
        input  fft_valid, fft_last, fft_re, fft_im, vs_in, data_req, fft_point_done,
        output fft_ready, fft_point_cnt, fft_data, frame_swapped, frame_err
    );
endinterface

// File: rtl/fft_spectrum_buf.sv
// rtl/fft_spectrum_buf.sv - ping-pong bar-height buffer between the FFT and the HDMI spectrum renderer
module fft_spectrum_buf #(
    parameter int FFT_POINT = 256,
    parameter int ADDR_BITS = 8,
    parameter int DATA_W    = 16,
    parameter int SHIFT     = 6,
    parameter int V_ACT     = 720
) (
    input  logic              pix_clk,
    input  logic              rst,
    fft_spectrum_buf_if.slave bus
);
    localparam int MAG_W = DATA_W + 1;
    localparam int HW    = $clog2(V_ACT);
    localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(FFT_POINT - 1);

    typedef enum logic [1:0] {W_FILL, W_DRAIN, W_FULL} wr_state_t;

    wr_state_t            state, state_nxt;
    logic [ADDR_BITS-1:0] wr_addr, wr_addr_nxt;
    logic                 wr_bank, wr_bank_nxt;
    logic                 disp_bank, disp_bank_nxt;
    logic                 disp_valid, disp_valid_nxt;
    logic                 vs_q, vs_rise, accept, swap, err_nxt;
    logic [ADDR_BITS-1:0] cnt, cnt_nxt;
    logic [31:0]          data_q, data_nxt;
    logic                 swapped_q, err_q;

    logic                 s1_v, s1_bank, s2_v, s2_bank;
    logic [ADDR_BITS-1:0] s1_addr, s2_addr;
    logic [MAG_W-1:0]     s1_mag, shifted;
    logic [HW-1:0]        s2_h, h_s1;

    logic [HW-1:0] mem [0:2*FFT_POINT-1];

    // Sign-extend before negating so the most negative input has an exact magnitude.
    function automatic logic [MAG_W-1:0] abs_ext(input logic signed [DATA_W-1:0] v);
        logic signed [MAG_W-1:0] e;
        e = {v[DATA_W-1], v};
        return v[DATA_W-1] ? MAG_W'(-e) : MAG_W'(e);
    endfunction

    assign vs_rise       = bus.vs_in & ~vs_q;
    assign bus.fft_ready = (state == W_FILL);
    assign accept        = bus.fft_valid & bus.fft_ready;
    assign shifted       = s1_mag >> SHIFT;
    assign h_s1          = (shifted > MAG_W'(V_ACT - 1)) ? HW'(V_ACT - 1) : shifted[HW-1:0];

    always_comb begin
        state_nxt      = state;
        wr_addr_nxt    = wr_addr;
        wr_bank_nxt    = wr_bank;
        disp_bank_nxt  = disp_bank;
        disp_valid_nxt = disp_valid;
        swap           = 1'b0;
        err_nxt        = 1'b0;
        case (state)
            W_FILL: begin
                if (accept) begin
                    if (bus.fft_last != (wr_addr == LAST)) begin
                        err_nxt     = 1'b1;
                        wr_addr_nxt = '0;
                    end else if (bus.fft_last) begin
                        state_nxt   = W_DRAIN;
                        wr_addr_nxt = '0;
                    end else begin
                        wr_addr_nxt = wr_addr + 1'b1;
                    end
                end
            end
            // Hold until the last bins are in RAM so a swap never races a pending write.
            W_DRAIN: if (!s1_v && !s2_v) state_nxt = W_FULL;
            W_FULL: begin
                if (vs_rise) begin
                    swap           = 1'b1;
                    state_nxt      = W_FILL;
                    wr_addr_nxt    = '0;
                    wr_bank_nxt    = ~wr_bank;
                    disp_bank_nxt  = wr_bank;
                    disp_valid_nxt = 1'b1;
                end
            end
            default: state_nxt = W_FILL;
        endcase

        if (vs_rise || bus.fft_point_done)       cnt_nxt = '0;
        else if (bus.data_req && cnt != LAST)    cnt_nxt = cnt + 1'b1;
        else                                     cnt_nxt = cnt;

        // Read at the next address so count and data change on the same edge.
        data_nxt = disp_valid_nxt ? 32'(mem[{disp_bank_nxt, cnt_nxt}]) : 32'd0;
    end

    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            state      <= W_FILL;
            wr_addr    <= '0;
            wr_bank    <= 1'b0;
            disp_bank  <= 1'b0;
            disp_valid <= 1'b0;
            vs_q       <= 1'b0;
            cnt        <= '0;
            data_q     <= '0;
            swapped_q  <= 1'b0;
            err_q      <= 1'b0;
            s1_v       <= 1'b0;
            s1_bank    <= 1'b0;
            s1_addr    <= '0;
            s1_mag     <= '0;
            s2_v       <= 1'b0;
            s2_bank    <= 1'b0;
            s2_addr    <= '0;
            s2_h       <= '0;
        end else begin
            state      <= state_nxt;
            wr_addr    <= wr_addr_nxt;
            wr_bank    <= wr_bank_nxt;
            disp_bank  <= disp_bank_nxt;
            disp_valid <= disp_valid_nxt;
            vs_q       <= bus.vs_in;
            cnt        <= cnt_nxt;
            data_q     <= data_nxt;
            swapped_q  <= swap;
            err_q      <= err_nxt;
            s1_v       <= accept;
            if (accept) begin
                s1_bank <= wr_bank;
                s1_addr <= wr_addr;
                s1_mag  <= abs_ext(bus.fft_re) + abs_ext(bus.fft_im);
            end
            s2_v    <= s1_v;
            s2_bank <= s1_bank;
            s2_addr <= s1_addr;
            s2_h    <= h_s1;
        end
    end

    always_ff @(posedge pix_clk) begin
        if (s2_v) mem[{s2_bank, s2_addr}] <= s2_h;
    end

    assign bus.fft_point_cnt = cnt;
    assign bus.fft_data      = data_q;
    assign bus.frame_swapped = swapped_q;
    assign bus.frame_err     = err_q;
endmodule
